// File: rtl/rf_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_pkg : shared register-file types and constants.  Rev 1.0
// ------------------------------------------------------------------
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    // Identifies a writeback source; used for the round-robin pointer.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arb2 : two-way round-robin grant, gated by an enable.  Rev 1.0
// ------------------------------------------------------------------
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    src_t r_rr_last;

    // On a tie the source that did not win last time gets the grant.
    assign gnt_a = en && req_a && (!req_b || (r_rr_last == SRC_B));
    assign gnt_b = en && req_b && (!req_a || (r_rr_last == SRC_A));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_last <= SRC_B;
        end else if (gnt_a) begin
            r_rr_last <= SRC_A;
        end else if (gnt_b) begin
            r_rr_last <= SRC_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rf_wb_arbiter : shares the RF write port between ALU (A) and LSU (B)
// writeback; optional bypass compare under RF_WB_FWD_EN.  Rev 1.0
// ------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rf_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
`ifdef RF_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_rs1,
    input  logic [ADDR_W-1:0] fwd_rs2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_rd;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic w_drain;
    logic w_can_load;
    logic w_gnt_a;
    logic w_gnt_b;

    assign w_drain    = r_out_valid && !rf_stall;
    assign w_can_load = !r_out_valid || w_drain;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en    (w_can_load),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (w_gnt_a),
        .gnt_b (w_gnt_b)
    );

    assign a_ready      = w_gnt_a;
    assign b_ready      = w_gnt_b;
    // x0 still occupies the stage for a drain cycle but never reaches the RF.
    assign rf_we        = w_drain && (r_out_rd != ADDR_W'(REG_ZERO));
    assign rf_waddr     = r_out_rd;
    assign rf_wdata     = r_out_data;
    assign busy         = r_out_valid;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid    <= 1'b0;
            r_out_rd       <= '0;
            r_out_data     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt_a) begin
                r_out_valid <= 1'b1;
                r_out_rd    <= a_rd;
                r_out_data  <= a_data;
            end else if (w_gnt_b) begin
                r_out_valid <= 1'b1;
                r_out_rd    <= b_rd;
                r_out_data  <= b_data;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (a_valid && b_valid && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

`ifdef RF_WB_FWD_EN
    assign fwd1_hit  = r_out_valid && (r_out_rd == fwd_rs1) && (fwd_rs1 != '0);
    assign fwd2_hit  = r_out_valid && (r_out_rd == fwd_rs2) && (fwd_rs2 != '0);
    assign fwd1_data = fwd1_hit ? r_out_data : '0;
    assign fwd2_data = fwd2_hit ? r_out_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rf_wb_arbiter : directed self-checking bench for rf_wb_arbiter.
// ------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid, rf_stall;
    logic              a_ready, b_ready, rf_we, busy;
    logic [ADDR_W-1:0] a_rd, b_rd, rf_waddr;
    logic [DATA_W-1:0] a_data, b_data, rf_wdata;
    logic [CNT_W-1:0]  conflict_cnt;
`ifdef RF_WB_FWD_EN
    logic [ADDR_W-1:0] fwd_rs1, fwd_rs2;
    logic              fwd1_hit, fwd2_hit;
    logic [DATA_W-1:0] fwd1_data, fwd2_data;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .rf_stall     (rf_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .fwd1_hit     (fwd1_hit),
        .fwd1_data    (fwd1_data),
        .fwd2_hit     (fwd2_hit),
        .fwd2_data    (fwd2_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rf_stall = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
`ifdef RF_WB_FWD_EN
        fwd_rs1 = '0; fwd_rs2 = '0;
`endif
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_we", rf_we, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_cnt", conflict_cnt, 0);

        // Contention from reset: A wins first tie, then alternation.
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            chk("cont_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                chk("cont_we", rf_we, 1);
                chk("cont_waddr", rf_waddr, (k % 2 == 1) ? 1 : 2);
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("cont_last_we", rf_we, 1);
        chk("cont_last_waddr", rf_waddr, 2);
        chk("cont_last_wdata", rf_wdata, 32'h22);
        chk("cont_cnt", conflict_cnt, 4);
        tick();
        chk("cont_idle", busy, 0);

        // Single source, one-cycle latency.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        chk("single_we_before", rf_we, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("single_we", rf_we, 1);
        chk("single_waddr", rf_waddr, 5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("single_drained", busy, 0);
        chk("single_we_after", rf_we, 0);

        // Stall with full stage; B waits behind it.
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
        tick();
        a_valid = 1'b0; rf_stall = 1'b1;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_we", rf_we, 0);
            chk("stall_a_ready", a_ready, 0);
            chk("stall_b_ready", b_ready, 0);
            chk("stall_busy", busy, 1);
            tick();
        end
        rf_stall = 1'b0;
        #1;
        chk("unstall_we", rf_we, 1);
        chk("unstall_waddr", rf_waddr, 3);
        chk("unstall_wdata", rf_wdata, 32'h33);
        chk("unstall_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("after_stall_waddr", rf_waddr, 4);
        chk("after_stall_wdata", rf_wdata, 32'h44);
        chk("after_stall_we", rf_we, 1);
        tick();
        chk("after_stall_idle", busy, 0);
        chk("stall_cnt_unchanged", conflict_cnt, 4);

        // Write to x0: accepted, occupies stage, never writes.
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
        #1;
        chk("x0_b_ready", b_ready, 1);
        chk("x0_we_pre", rf_we, 0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("x0_busy", busy, 1);
        chk("x0_we", rf_we, 0);
        tick();
        chk("x0_busy_after", busy, 0);
        chk("x0_we_after", rf_we, 0);

`ifdef RF_WB_FWD_EN
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1234;
        tick();
        a_valid = 1'b0; rf_stall = 1'b1; fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
        #1;
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_data", fwd1_data, 32'h1234);
        chk("fwd2_hit", fwd2_hit, 0);
        chk("fwd2_data", fwd2_data, 0);
        rf_stall = 1'b0;
        tick();
        chk("fwd1_hit_drained", fwd1_hit, 0);
`endif

        // Reset in the middle of a stalled transfer.
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
        tick();
        a_valid = 1'b0; rf_stall = 1'b1;
        #1;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1; rf_stall = 1'b0;
        #1;
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_we", rf_we, 0);
        chk("mid_reset_cnt", conflict_cnt, 0);

        // rr_last back to B: A wins the tie; then saturate the counter.
        a_valid = 1'b1; a_rd = 5'd1; b_valid = 1'b1; b_rd = 5'd2;
        #1;
        chk("mid_reset_a_first", a_ready, 1);
        chk("mid_reset_b_wait", b_ready, 0);
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        chk("cnt_fffe", conflict_cnt, 16'hFFFE);
        tick();
        chk("cnt_ffff", conflict_cnt, 16'hFFFF);
        for (int k = 0; k < 5; k++) @(posedge clk);
        #1;
        chk("cnt_saturated", conflict_cnt, 16'hFFFF);
        a_valid = 1'b0; b_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
